// File: rtl/mult_share_pkg.sv
// Shared types and default widths for the four-way shared multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_share_pkg;

    localparam int INPUT_WIDTH  = 14;
    localparam int OUTPUT_WIDTH = 2 * INPUT_WIDTH;
    localparam int NUM_REQ      = 4;
    localparam int STAT_WIDTH   = 16;

    typedef logic [1:0] req_id_t;

    // Operands captured at grant time, tagged with the owner
    typedef struct packed {
        logic [INPUT_WIDTH-1:0] a;
        logic [INPUT_WIDTH-1:0] b;
        req_id_t                id;
        logic                   v;
    } stage_t;

    // Finished product waiting on the output
    typedef struct packed {
        logic [OUTPUT_WIDTH-1:0] p;
        req_id_t                 id;
        logic                    v;
    } prod_t;

    // Round-robin successor of a requester index (wraps 3 -> 0)
    function automatic req_id_t rr_next(input req_id_t idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr.sv
// Four-way round-robin arbiter: one-hot grant starting the search at ptr.
// Latency: grant is combinational from req and ptr; ptr updates on the grant edge.
// Backpressure: none; a dropped req simply loses its turn, gnt is 0 in reset.
module rr_arbiter_4
    import mult_share_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output req_id_t    gnt_idx,
    output logic       gnt_vld
);

    req_id_t ptr_q;
    req_id_t ptr_d;
    req_id_t cand;

    // Search from the farthest slot back to ptr so the nearest requester wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (req[cand]) begin
                gnt_idx = cand;
                gnt_vld = 1'b1;
            end
        end
        if (!reset) begin
            gnt_vld = 1'b0;
        end
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Pointer moves past the winner; holds when nobody was granted
    always_comb begin
        ptr_d = gnt_vld ? rr_next(gnt_idx) : ptr_q;
    end

    // Pointer register with synchronous reset to requester 0
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one registered 14x14 unsigned multiplier among four round-robin requesters.
// Latency: 2 edges from grant to y_valid; one issue per cycle sustained.
// Backpressure: none downstream; requesters wait on gnt. Option MULT_ARB_STATS_EN adds grant_cnt.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    // Widths must match the package defaults, which size stage_t/prod_t
    parameter int INPUT_WIDTH  = mult_share_pkg::INPUT_WIDTH,
    parameter int OUTPUT_WIDTH = mult_share_pkg::OUTPUT_WIDTH,
    parameter int NUM_REQ      = mult_share_pkg::NUM_REQ
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] a_in,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] b_in,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [OUTPUT_WIDTH-1:0]        y,
    output logic                           y_valid,
    output logic [1:0]                     y_id
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_WIDTH-1:0]  grant_cnt
`endif
);

    req_id_t gnt_idx;
    logic    gnt_vld;
    stage_t  s1_q, s1_d;
    prod_t   s2_q, s2_d;

    rr_arbiter_4 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Operand mux: capture the winner's operands; idle cycles only clear v
    always_comb begin
        s1_d   = s1_q;
        s1_d.v = gnt_vld;
        if (gnt_vld) begin
            s1_d.a  = a_in[gnt_idx*INPUT_WIDTH +: INPUT_WIDTH];
            s1_d.b  = b_in[gnt_idx*INPUT_WIDTH +: INPUT_WIDTH];
            s1_d.id = gnt_idx;
        end
    end

    // Multiply stage: product and id only change on a valid slot so y holds when idle
    always_comb begin
        s2_d   = s2_q;
        s2_d.v = s1_q.v;
        if (s1_q.v) begin
            s2_d.p  = OUTPUT_WIDTH'(s1_q.a) * OUTPUT_WIDTH'(s1_q.b);
            s2_d.id = s1_q.id;
        end
    end

    // Pipeline registers; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Outputs come straight from the second stage
    always_comb begin
        y       = s2_q.p;
        y_valid = s2_q.v;
        y_id    = s2_q.id;
    end

`ifdef MULT_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] cnt_q [NUM_REQ];

    // Per-requester saturating grant counters
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!reset) begin
                cnt_q[i] <= '0;
            end else if (gnt[i] && (cnt_q[i] != {STAT_WIDTH{1'b1}})) begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    // Flatten counters onto the stats port, requester i in slice i
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*STAT_WIDTH +: STAT_WIDTH] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a result scoreboard.
// Latency: expects each product two edges after its grant.
// Backpressure: none; bench drives one cycle of stimulus per call.
module tb_mult_share_arbiter;

    localparam int IW = 14;
    localparam int OW = 28;
    localparam int NR = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req;
    logic [NR*IW-1:0] a_in;
    logic [NR*IW-1:0] b_in;
    logic [NR-1:0]    gnt;
    logic [OW-1:0]    y;
    logic             y_valid;
    logic [1:0]       y_id;
`ifdef MULT_ARB_STATS_EN
    logic [NR*16-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    mult_share_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .y         (y),
        .y_valid   (y_valid),
        .y_id      (y_id)
`ifdef MULT_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    typedef struct {
        logic [OW-1:0] y;
        logic [1:0]    id;
        int            due;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    logic [1:0]    ptr_m  = 2'd0;
    logic [OW-1:0] last_y = '0;
    logic [1:0]    last_id = 2'd0;
    logic          rst_seen = 1'b0;
    bit            mon_en = 1'b0;
    logic [IW-1:0] a_arr [NR];
    logic [IW-1:0] b_arr [NR];

    always @(posedge clk) begin
        cyc++;
        rst_seen = reset;
    end

    // Output monitor: pops the scoreboard on y_valid, checks hold and reset values otherwise
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (!rst_seen) begin
                checks++;
                if (y !== '0 || y_valid !== 1'b0 || y_id !== 2'd0) begin
                    errors++;
                    $display("FAIL reset_out: y=%h y_valid=%b y_id=%0d, required 0/0/0", y, y_valid, y_id);
                end
                last_y  = '0;
                last_id = 2'd0;
            end else begin
                while (sb.size() > 0 && sb[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_result: y=%h id=%0d due cycle %0d not seen", sb[0].y, sb[0].id, sb[0].due);
                    void'(sb.pop_front());
                end
                checks++;
                if (y_valid === 1'b1) begin
                    if (sb.size() == 0 || sb[0].due != cyc) begin
                        errors++;
                        $display("FAIL unexpected_valid: y=%h y_id=%0d at cycle %0d, required no valid", y, y_id, cyc);
                        last_y  = y;
                        last_id = y_id;
                    end else begin
                        e = sb.pop_front();
                        if (y !== e.y || y_id !== e.id) begin
                            errors++;
                            $display("FAIL result: y=%h y_id=%0d, required y=%h y_id=%0d", y, y_id, e.y, e.id);
                        end
                        last_y  = e.y;
                        last_id = e.id;
                    end
                end else if (y_valid !== 1'b0 || y !== last_y || y_id !== last_id) begin
                    errors++;
                    $display("FAIL idle_hold: y_valid=%b y=%h y_id=%0d, required 0 %h %0d", y_valid, y, y_id, last_y, last_id);
                end
            end
        end
    end

    // One cycle of stimulus; checks gnt against the reference arbiter and queues the product
    task automatic drive(input logic rst, input logic [3:0] r);
        logic [3:0] g_exp;
        logic [1:0] idx;
        bit         found;
        exp_t       e;
        @(posedge clk);
        #1;
        reset = rst;
        req   = r;
        for (int i = 0; i < NR; i++) begin
            a_in[i*IW +: IW] = a_arr[i];
            b_in[i*IW +: IW] = b_arr[i];
        end
        #1;
        g_exp = 4'b0;
        found = 1'b0;
        idx   = 2'd0;
        if (rst) begin
            for (int k = 0; k < NR; k++) begin
                if (!found) begin
                    idx = ptr_m + 2'(k);
                    if (r[idx]) begin
                        found      = 1'b1;
                        g_exp[idx] = 1'b1;
                    end
                end
            end
        end
        checks++;
        if (gnt !== g_exp) begin
            errors++;
            $display("FAIL gnt: gnt=%b req=%b rst=%b, required %b", gnt, r, rst, g_exp);
        end
        if (!rst) begin
            ptr_m = 2'd0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due > cyc) sb.delete(i);
            end
        end else if (found) begin
            e.y   = OW'(a_arr[idx]) * OW'(b_arr[idx]);
            e.id  = idx;
            e.due = cyc + 2;
            sb.push_back(e);
            ptr_m = idx + 2'd1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = 4'hF;
        a_in  = '0;
        b_in  = '0;
        for (int i = 0; i < NR; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            mon_en = 1'b1;
            checks++;
            if (gnt !== 4'b0 || y !== '0 || y_valid !== 1'b0 || y_id !== 2'd0) begin
                errors++;
                $display("FAIL reset_state: gnt=%b y=%h y_valid=%b y_id=%0d, required all 0", gnt, y, y_valid, y_id);
            end
        end
        ptr_m = 2'd0;
    endtask

    task automatic test_single();
        a_arr[2] = 14'd3;
        b_arr[2] = 14'd5;
        drive(1'b1, 4'b0100);
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL single_gnt: gnt=%b, required 0100", gnt);
        end
        drive(1'b1, 4'b0000);
        drive(1'b1, 4'b0000);
        checks++;
        if (y_valid !== 1'b1 || y !== 28'd15 || y_id !== 2'd2) begin
            errors++;
            $display("FAIL single_result: y_valid=%b y=%0d y_id=%0d, required 1 15 2", y_valid, y, y_id);
        end
        drive(1'b1, 4'b0000);
        checks++;
        if (y_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: y_valid=%b one cycle later, required 0", y_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] g_req;
        drive(1'b0, 4'b0000);
        for (int i = 0; i < NR; i++) begin
            a_arr[i] = 14'(i + 1);
            b_arr[i] = 14'd2;
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 4'hF);
            g_req = 4'b0001 << (k % 4);
            checks++;
            if (gnt !== g_req) begin
                errors++;
                $display("FAIL rr_order: step %0d gnt=%b, required %b", k, gnt, g_req);
            end
        end
        for (int k = 0; k < 3; k++) drive(1'b1, 4'b0000);
    endtask

    task automatic test_deassert();
        drive(1'b1, 4'b0011);
        drive(1'b1, 4'b0001);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL dropped_req: gnt=%b, required 0001", gnt);
        end
        for (int k = 0; k < 3; k++) drive(1'b1, 4'b0000);
    endtask

    task automatic test_max_operands();
        a_arr[3] = 14'h3FFF;
        b_arr[3] = 14'h3FFF;
        drive(1'b1, 4'b1000);
        drive(1'b1, 4'b0000);
        drive(1'b1, 4'b0000);
        checks++;
        if (y_valid !== 1'b1 || y !== 28'h0FFF8001 || y_id !== 2'd3) begin
            errors++;
            $display("FAIL max_operands: y_valid=%b y=%h y_id=%0d, required 1 0FFF8001 3", y_valid, y, y_id);
        end
        drive(1'b1, 4'b0000);
    endtask

    task automatic test_reset_mid_flight();
        drive(1'b1, 4'b0010);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL midflight_gnt: gnt=%b, required 0010", gnt);
        end
        drive(1'b0, 4'hF);
        drive(1'b0, 4'hF);
        drive(1'b1, 4'hF);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL ptr_after_reset: gnt=%b, required 0001", gnt);
        end
        for (int k = 0; k < 4; k++) drive(1'b1, 4'b0000);
    endtask

`ifdef MULT_ARB_STATS_EN
    task automatic test_stats();
        drive(1'b0, 4'b0000);
        for (int k = 0; k < 70000; k++) drive(1'b1, 4'b0001);
        drive(1'b1, 4'b0000);
        checks++;
        if (grant_cnt !== {16'h0, 16'h0, 16'h0, 16'hFFFF}) begin
            errors++;
            $display("FAIL stats_saturate: grant_cnt=%h, required 000000000000FFFF", grant_cnt);
        end
        for (int k = 0; k < 3; k++) drive(1'b1, 4'b0000);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_deassert();
        test_max_operands();
        test_reset_mid_flight();
`ifdef MULT_ARB_STATS_EN
        test_stats();
`endif
        for (int k = 0; k < 4; k++) drive(1'b1, 4'b0000);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
